// File: rtl/dsa_fetch_pkg.sv
// Shared types and constants for the bilinear neighbour fetch block.
package dsa_fetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StHold
   } fetch_state_e;

   localparam int unsigned MEM_RD_LAT    = 1;
   localparam int unsigned NUM_NEIGHBORS = 4;
   localparam int unsigned NB_IDX_W      = $clog2(NUM_NEIGHBORS);

endpackage

// File: rtl/dsa_neighbor_fetch_if.sv
// Request, memory read port and quad output bundle of dsa_neighbor_fetch.
interface dsa_neighbor_fetch_if #(
   parameter int unsigned ADDR_WIDTH  = 18,
   parameter int unsigned COORD_WIDTH = 10
);

   logic                   req_valid;
   logic                   req_ready;
   logic [COORD_WIDTH-1:0] req_x;
   logic [COORD_WIDTH-1:0] req_y;
   logic [ADDR_WIDTH-1:0]  img_base;
   logic [COORD_WIDTH-1:0] img_width;
   logic [COORD_WIDTH-1:0] img_height;
   logic                   mem_read_en;
   logic [ADDR_WIDTH-1:0]  mem_read_addr;
   logic [7:0]             mem_read_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             out_p00;
   logic [7:0]             out_p01;
   logic [7:0]             out_p10;
   logic [7:0]             out_p11;
   logic [31:0]            fetch_count;

   // Fetch block side.
   modport slave (
      input  req_valid, req_x, req_y, img_base, img_width, img_height,
      output req_ready,
      output mem_read_en, mem_read_addr,
      input  mem_read_data,
      output out_valid, out_p00, out_p01, out_p10, out_p11, fetch_count,
      input  out_ready
   );

   // Environment side: coordinate source, memory and consumer.
   modport master (
      output req_valid, req_x, req_y, img_base, img_width, img_height,
      input  req_ready,
      input  mem_read_en, mem_read_addr,
      output mem_read_data,
      input  out_valid, out_p00, out_p01, out_p10, out_p11, fetch_count,
      output out_ready
   );

endinterface

// File: rtl/dsa_fetch_addr_gen.sv
// Registers clamped neighbour coordinates and row bases at accept, then
// selects one of the four neighbour addresses by index.
module dsa_fetch_addr_gen
   import dsa_fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 18,
   parameter int unsigned COORD_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [COORD_WIDTH-1:0] x,
   input  logic [COORD_WIDTH-1:0] y,
   input  logic [COORD_WIDTH-1:0] width,
   input  logic [COORD_WIDTH-1:0] height,
   input  logic [ADDR_WIDTH-1:0]  base,
   input  logic [NB_IDX_W-1:0]    sel,
   output logic [ADDR_WIDTH-1:0]  addr
);

   localparam int unsigned PW = 2 * COORD_WIDTH;

   // Zero-extend or truncate to the address width; all address math wraps.
   function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [PW-1:0] v);
      logic [PW+ADDR_WIDTH-1:0] ext;
      ext = {{ADDR_WIDTH{1'b0}}, v};
      return ext[ADDR_WIDTH-1:0];
   endfunction

   logic [COORD_WIDTH:0]   x_inc, y_inc, x_lim, y_lim;
   logic [COORD_WIDTH-1:0] x1, y1;
   logic [PW-1:0]          prod0, prod1;
   logic [ADDR_WIDTH-1:0]  row0_d, row1_d;

   logic [ADDR_WIDTH-1:0]  row0_q, row1_q, x0_q, x1_q;

   always_comb begin
      x_inc  = {1'b0, x} + 1'b1;
      y_inc  = {1'b0, y} + 1'b1;
      x_lim  = {1'b0, width} - 1'b1;
      y_lim  = {1'b0, height} - 1'b1;
      x1     = (x_inc > x_lim) ? x_lim[COORD_WIDTH-1:0] : x_inc[COORD_WIDTH-1:0];
      y1     = (y_inc > y_lim) ? y_lim[COORD_WIDTH-1:0] : y_inc[COORD_WIDTH-1:0];
      prod0  = PW'(y) * PW'(width);
      prod1  = PW'(y1) * PW'(width);
      row0_d = base + to_addr(prod0);
      row1_d = base + to_addr(prod1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row0_q <= '0;
         row1_q <= '0;
         x0_q   <= '0;
         x1_q   <= '0;
      end else if (load) begin
         row0_q <= row0_d;
         row1_q <= row1_d;
         x0_q   <= to_addr(PW'(x));
         x1_q   <= to_addr(PW'(x1));
      end
   end

   always_comb begin
      addr = '0;
      unique case (sel)
         2'd0: addr = row0_q + x0_q;
         2'd1: addr = row0_q + x1_q;
         2'd2: addr = row1_q + x0_q;
         2'd3: addr = row1_q + x1_q;
         default: addr = '0;
      endcase
   end

endmodule

// File: rtl/dsa_neighbor_fetch.sv
// Fetches the 2x2 bilinear neighbourhood of one coordinate over a single read port.
// Optional fetch counter enabled by defining FETCH_STATS_EN.
module dsa_neighbor_fetch
   import dsa_fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 18,
   parameter int unsigned COORD_WIDTH = 10
) (
   input logic                 clk,
   input logic                 rst,
   dsa_neighbor_fetch_if.slave bus
);

   fetch_state_e          state_q, state_d;
   logic [NB_IDX_W-1:0]   k_q, k_d;
   logic                  rd_vld_q [MEM_RD_LAT];
   logic [NB_IDX_W-1:0]   rd_idx_q [MEM_RD_LAT];
   logic [7:0]            pix_q [NUM_NEIGHBORS];

   logic                  req_ready;
   logic                  load;
   logic                  issue;
   logic                  cap_last;
   logic                  hs;
   logic [ADDR_WIDTH-1:0] gen_addr;

   assign req_ready = (state_q == StIdle) && !rst;
   assign load      = req_ready && bus.req_valid;
   assign issue     = (state_q == StIssue);
   assign hs        = (state_q == StHold) && bus.out_ready;
   assign cap_last  = rd_vld_q[MEM_RD_LAT-1] &&
                      (rd_idx_q[MEM_RD_LAT-1] == NB_IDX_W'(NUM_NEIGHBORS - 1));

   dsa_fetch_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .COORD_WIDTH(COORD_WIDTH)
   ) u_addr_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .x     (bus.req_x),
      .y     (bus.req_y),
      .width (bus.img_width),
      .height(bus.img_height),
      .base  (bus.img_base),
      .sel   (k_q),
      .addr  (gen_addr)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               state_d = StIssue;
               k_d     = '0;
            end
         end
         StIssue: begin
            k_d = k_q + 1'b1;
            if (k_q == NB_IDX_W'(NUM_NEIGHBORS - 1)) state_d = StDrain;
         end
         StDrain: begin
            if (cap_last) state_d = StHold;
         end
         StHold: begin
            if (hs) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Read-return pipeline: tags each strobe with its neighbour slot until data lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_RD_LAT; i++) begin
            rd_vld_q[i] <= 1'b0;
            rd_idx_q[i] <= '0;
         end
      end else begin
         rd_vld_q[0] <= issue;
         rd_idx_q[0] <= k_q;
         for (int i = 1; i < MEM_RD_LAT; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            rd_idx_q[i] <= rd_idx_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEIGHBORS; i++) pix_q[i] <= '0;
      end else if (rd_vld_q[MEM_RD_LAT-1]) begin
         pix_q[rd_idx_q[MEM_RD_LAT-1]] <= bus.mem_read_data;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_q <= '0;
      end else if (hs) begin
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end

   assign bus.fetch_count = fetch_count_q;
`else
   assign bus.fetch_count = '0;
`endif

   assign bus.req_ready     = req_ready;
   assign bus.mem_read_en   = issue;
   assign bus.mem_read_addr = issue ? gen_addr : '0;
   assign bus.out_valid     = (state_q == StHold);
   assign bus.out_p00       = pix_q[0];
   assign bus.out_p01       = pix_q[1];
   assign bus.out_p10       = pix_q[2];
   assign bus.out_p11       = pix_q[3];

endmodule

// File: tb/tb_dsa_neighbor_fetch.sv
// Directed bench for dsa_neighbor_fetch; memory returns the low address byte.
module tb_dsa_neighbor_fetch;

   typedef struct packed {
      logic [9:0]       x;
      logic [9:0]       y;
      logic [9:0]       w;
      logic [9:0]       h;
      logic [17:0]      base;
      logic [3:0][17:0] a;
   } vec_t;

   localparam int NVEC = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] mem_q = 8'h00;
   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   dsa_neighbor_fetch_if #(.ADDR_WIDTH(18), .COORD_WIDTH(10)) bus ();

   dsa_neighbor_fetch #(
      .ADDR_WIDTH (18),
      .COORD_WIDTH(10)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Synchronous memory with one cycle of read latency.
   always @(posedge clk) begin
      if (bus.mem_read_en) mem_q <= bus.mem_read_addr[7:0];
   end
   assign bus.mem_read_data = mem_q;

   always @(posedge clk) begin
      if (rst) hs_cnt <= 0;
      else if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic vec_t mk(input int x, input int y, input int w, input int h,
                               input int base, input int a0, input int a1,
                               input int a2, input int a3);
      vec_t v;
      v.x    = 10'(x);
      v.y    = 10'(y);
      v.w    = 10'(w);
      v.h    = 10'(h);
      v.base = 18'(base);
      v.a[0] = 18'(a0);
      v.a[1] = 18'(a1);
      v.a[2] = 18'(a2);
      v.a[3] = 18'(a3);
      return v;
   endfunction

   function automatic logic [31:0] exp_count();
`ifdef FETCH_STATS_EN
      return 32'(hs_cnt);
`else
      return 32'd0;
`endif
   endfunction

   // Entered at a negedge in IDLE; returns at the negedge of the first HOLD cycle.
   task automatic run_fetch(input vec_t v, input string tag);
      bus.req_x      = v.x;
      bus.req_y      = v.y;
      bus.img_width  = v.w;
      bus.img_height = v.h;
      bus.img_base   = v.base;
      bus.req_valid  = 1'b1;
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk({tag, "_rd_en"}, 32'(bus.mem_read_en), 32'd1);
         chk({tag, "_rd_addr"}, 32'(bus.mem_read_addr), 32'(v.a[c]));
         if (c == 0) chk({tag, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_drain_en"}, 32'(bus.mem_read_en), 32'd0);
      chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_quad"}, {bus.out_p00, bus.out_p01, bus.out_p10, bus.out_p11},
          {v.a[0][7:0], v.a[1][7:0], v.a[2][7:0], v.a[3][7:0]});
   endtask

   vec_t vecs [NVEC];

   initial begin
      logic [31:0] held;
      int t_ov [5];
      int n_ov;
      int bad;

      vecs[0] = mk(2, 3, 8, 8, 0, 26, 27, 34, 35);
      vecs[1] = mk(7, 7, 8, 8, 0, 63, 63, 63, 63);
      vecs[2] = mk(1, 0, 4, 4, 262140, 262141, 262142, 1, 2);
      vecs[3] = mk(9, 4, 10, 5, 100, 149, 149, 149, 149);
      vecs[4] = mk(0, 1, 5, 3, 1000, 1005, 1006, 1010, 1011);
      vecs[5] = mk(0, 0, 1, 1, 7, 7, 7, 7, 7);
      vecs[6] = mk(0, 999, 1000, 1000, 0, 212568, 212569, 212568, 212569);
      vecs[7] = mk(5, 2, 6, 9, 50, 67, 67, 73, 73);

      bus.req_valid  = 1'b0;
      bus.req_x      = '0;
      bus.req_y      = '0;
      bus.img_base   = '0;
      bus.img_width  = 10'd1;
      bus.img_height = 10'd1;
      bus.out_ready  = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_rd_en", 32'(bus.mem_read_en), 32'd0);
      chk("post_rst_rd_addr", 32'(bus.mem_read_addr), 32'd0);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_quad", {bus.out_p00, bus.out_p01, bus.out_p10, bus.out_p11}, 32'd0);
      chk("post_rst_count", bus.fetch_count, 32'd0);

      // Table of single fetches with out_ready high.
      for (int i = 0; i < NVEC; i++) begin
         run_fetch(vecs[i], $sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d_done_valid", i), 32'(bus.out_valid), 32'd0);
         chk($sformatf("vec%0d_done_ready", i), 32'(bus.req_ready), 32'd1);
      end

      // Backpressure: quad held, new requests ignored, no reads.
      bus.out_ready = 1'b0;
      run_fetch(vecs[4], "bp");
      held = {bus.out_p00, bus.out_p01, bus.out_p10, bus.out_p11};
      bus.req_x     = 10'd3;
      bus.req_y     = 10'd3;
      bus.req_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         chk("bp_rd_en", 32'(bus.mem_read_en), 32'd0);
         chk("bp_quad_stable", {bus.out_p00, bus.out_p01, bus.out_p10, bus.out_p11}, held);
      end
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      bad = hs_cnt;
      @(negedge clk);
      chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      chk("bp_single_hs", 32'(hs_cnt - bad), 32'd1);
      chk("bp_idle_rd_en", 32'(bus.mem_read_en), 32'd0);
      chk("count_before_rst", bus.fetch_count, exp_count());

      // Reset on the second read strobe aborts the fetch.
      bus.req_x      = 10'd2;
      bus.req_y      = 10'd3;
      bus.img_width  = 10'd8;
      bus.img_height = 10'd8;
      bus.img_base   = '0;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_strobe2", 32'(bus.mem_read_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rd_en", 32'(bus.mem_read_en), 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready_after", 32'(bus.req_ready), 32'd1);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.out_valid || bus.mem_read_en) bad++;
         @(negedge clk);
      end
      chk("mid_rst_no_stale", 32'(bad), 32'd0);
      chk("mid_rst_quad_clear", {bus.out_p00, bus.out_p01, bus.out_p10, bus.out_p11}, 32'd0);
      chk("mid_rst_count", bus.fetch_count, 32'd0);

      // Back-to-back: five quads, one every 7 cycles.
      bus.req_x      = 10'd2;
      bus.req_y      = 10'd3;
      bus.img_width  = 10'd8;
      bus.img_height = 10'd8;
      bus.img_base   = '0;
      bus.req_valid  = 1'b1;
      n_ov = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (bus.out_valid) begin
            t_ov[n_ov] = cyc;
            n_ov++;
            if (n_ov == 5) begin
               bus.req_valid = 1'b0;
               break;
            end
         end
         @(negedge clk);
      end
      chk("b2b_quads", 32'(n_ov), 32'd5);
      if (n_ov == 5) begin
         chk("b2b_first_latency", 32'(t_ov[0]), 32'd6);
         for (int i = 1; i < 5; i++) chk("b2b_period", 32'(t_ov[i] - t_ov[i-1]), 32'd7);
      end
      @(negedge clk);
      chk("b2b_hs", 32'(hs_cnt), 32'd5);
`ifdef FETCH_STATS_EN
      chk("b2b_fetch_count", bus.fetch_count, 32'd5);
`else
      chk("b2b_fetch_count", bus.fetch_count, 32'd0);
`endif
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.out_valid || bus.mem_read_en) bad++;
      end
      chk("b2b_quiet", 32'(bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
